// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage.
// Operands are captured through the forwarding mux on the start cycle; the loop runs on magnitudes.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_start_EX,
  input  logic [2:0]      funct3_EX,
  input  logic [XLEN-1:0] rs1_data_EX,
  input  logic [XLEN-1:0] rs2_data_EX,
  input  logic [XLEN-1:0] fwd_data_MEM,
  input  logic [XLEN-1:0] fwd_data_WB,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic            flush_EX,
  input  logic            hold_EX,
  output logic            stall_md,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result,
  output logic            md_busy
);

  // state | meaning
  // IDLE  | waiting for an M instruction in EX
  // CALC  | one shift-add / shift-subtract iteration per cycle
  // DONE  | result presented; held here while hold_EX is set
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(ITER);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   divisor;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [XLEN-1:0]   res_q;

  logic [XLEN-1:0] op_a, op_b, mag_a, mag_b, fast_res;
  logic            sgn_a, sgn_b, neg_a, neg_b, is_div, div_zero, div_ovf, fast, neg_in;

  always_comb begin
    op_a = rs1_data_EX;
    op_b = rs2_data_EX;
    case (forwardA)
      2'b01:   op_a = fwd_data_WB;
      2'b10:   op_a = fwd_data_MEM;
      default: op_a = rs1_data_EX;
    endcase
    case (forwardB)
      2'b01:   op_b = fwd_data_WB;
      2'b10:   op_b = fwd_data_MEM;
      default: op_b = rs2_data_EX;
    endcase
  end

  assign sgn_a    = (funct3_EX == 3'b001) | (funct3_EX == 3'b010) |
                    (funct3_EX == 3'b100) | (funct3_EX == 3'b110);
  assign sgn_b    = (funct3_EX == 3'b001) | (funct3_EX == 3'b100) | (funct3_EX == 3'b110);
  assign neg_a    = sgn_a & op_a[XLEN-1];
  assign neg_b    = sgn_b & op_b[XLEN-1];
  assign mag_a    = neg_a ? -op_a : op_a;
  assign mag_b    = neg_b ? -op_b : op_b;
  assign is_div   = funct3_EX[2];
  assign div_zero = (op_b == '0);
  assign div_ovf  = sgn_b & (op_a == MIN_NEG) & (op_b == ALL_ONE);
  assign fast     = is_div & (div_zero | div_ovf);
  // Remainder takes the dividend's sign; product and quotient take the XOR.
  assign neg_in   = (is_div & funct3_EX[1]) ? neg_a : (neg_a ^ neg_b);
  assign fast_res = funct3_EX[1] ? (div_zero ? op_a : '0) : (div_zero ? ALL_ONE : MIN_NEG);

  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_sub, quo, rem;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_next, prod;
  logic [XLEN-1:0]   fin_res;

  // Upper half is the partial product (multiply) or partial remainder (divide).
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : '0);
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, divisor});
  assign div_sub   = div_shift[XLEN-1:0] - divisor;
  assign acc_next  = f3_q[2] ?
                     {(div_ge ? div_sub : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge} :
                     {mul_sum, acc[XLEN-1:1]};
  assign prod      = neg_q ? -acc_next : acc_next;
  assign quo       = acc_next[XLEN-1:0];
  assign rem       = acc_next[2*XLEN-1:XLEN];

  always_comb begin
    fin_res = '0;
    case (f3_q)
      3'b000:                 fin_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = neg_q ? -quo : quo;
      default:                fin_res = neg_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      divisor <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start_EX && !flush_EX) begin
            acc     <= {{XLEN{1'b0}}, mag_a};
            divisor <= mag_b;
            f3_q    <= funct3_EX;
            neg_q   <= neg_in;
            cnt     <= CW'(ITER - 1);
            if (fast) begin
              res_q <= fast_res;
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_EX) begin
            state <= IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              res_q <= fin_res;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (flush_EX || !hold_EX) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_md  = ((state == IDLE) & md_start_EX & ~flush_EX) | (state == CALC);
  assign md_valid  = (state == DONE) & ~flush_EX;
  assign md_result = md_valid ? res_q : '0;
  assign md_busy   = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases plus randomized operations against an arithmetic model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        md_start_EX;
  logic [2:0]  funct3_EX;
  logic [31:0] rs1_data_EX, rs2_data_EX, fwd_data_MEM, fwd_data_WB;
  logic [1:0]  forwardA, forwardB;
  logic        flush_EX, hold_EX;
  logic        stall_md, md_valid, md_busy;
  logic [31:0] md_result;

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .md_start_EX(md_start_EX), .funct3_EX(funct3_EX),
    .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX),
    .fwd_data_MEM(fwd_data_MEM), .fwd_data_WB(fwd_data_WB),
    .forwardA(forwardA), .forwardB(forwardB), .flush_EX(flush_EX), .hold_EX(hold_EX),
    .stall_md(stall_md), .md_valid(md_valid), .md_result(md_result), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    logic [2:0]  f3;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] code, input logic [31:0] rf,
                                       input logic [31:0] mem, input logic [31:0] wb);
    if (code == 2'b01) return wb;
    if (code == 2'b10) return mem;
    return rf;
  endfunction

  // Monitor: first valid cycle of each result pops the scoreboard; held cycles must repeat it.
  bit          mon_en = 1'b0;
  bit          prev_valid = 1'b0, prev_hold = 1'b0;
  logic [31:0] last_res = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (md_valid) begin
        if (prev_valid && prev_hold) begin
          chk("hold_stable", md_result, last_res);
        end else if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=%h required=no_valid (cycle %0d)", md_result, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("result_f3_%0d", e.f3), md_result, e.res);
          chk("valid_cycle", 32'(cyc), 32'(e.cyc));
          chk("stall_at_done", {31'b0, stall_md}, 32'd0);
          last_res = e.res;
        end
      end else begin
        chk("result_zero_when_invalid", md_result, 32'd0);
      end
      prev_valid = md_valid;
      prev_hold  = hold_EX;
    end
  end

  task automatic scramble();
    rs1_data_EX  = $urandom;
    rs2_data_EX  = $urandom;
    fwd_data_MEM = $urandom;
    fwd_data_WB  = $urandom;
    forwardA     = 2'($urandom_range(0, 3));
    forwardB     = 2'($urandom_range(0, 3));
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] mem, input logic [31:0] wb,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input bit push, input logic [31:0] want, output int t, output int lat);
    logic [31:0] a, b;
    @(posedge clk); #1;
    md_start_EX = 1'b1; funct3_EX = f3;
    rs1_data_EX = r1; rs2_data_EX = r2; fwd_data_MEM = mem; fwd_data_WB = wb;
    forwardA = fa; forwardB = fb;
    t = cyc;
    a = pick(fa, r1, mem, wb);
    b = pick(fb, r2, mem, wb);
    lat = ref_lat(f3, a, b);
    if (push) q.push_back('{res: want, cyc: t + lat, f3: f3});
    #1;
    chk("stall_capture", {31'b0, stall_md}, 32'd1);
    @(posedge clk); #1;
    md_start_EX = 1'b0;
    scramble();
  endtask

  task automatic wait_drain(input int lat);
    int n, stl;
    n = 0;
    stl = 1;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (stall_md) stl++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=pending_%0d required=0", q.size());
      q.delete();
    end else begin
      chk("stall_cycles", 32'(stl), 32'(lat));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_stall"}, {31'b0, stall_md}, 32'd0);
    chk({tag, "_valid"}, {31'b0, md_valid}, 32'd0);
    chk({tag, "_result"}, md_result, 32'd0);
    chk({tag, "_busy"}, {31'b0, md_busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, lat;
    logic [31:0] r1, r2, mem, wb, a, b;
    logic [2:0]  f3;
    logic [1:0]  fa, fb;
    logic [31:0] specials [6];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

    rst = 1'b1; md_start_EX = 1'b0; funct3_EX = '0; flush_EX = 1'b0; hold_EX = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // MUL 7 x -3 from the register file
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, $urandom, $urandom, 2'b00, 2'b00, 1, 32'hFFFF_FFEB, t, lat);
    wait_drain(lat);
    // MULHU with rs1 forwarded from MEM, MEM turning to garbage afterwards
    issue(3'b011, $urandom, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $urandom, 2'b10, 2'b00, 1, 32'hFFFF_FFFE, t, lat);
    wait_drain(lat);
    // DIV and REM -7 / 2 with rs2 forwarded from WB
    issue(3'b100, 32'hFFFF_FFF9, $urandom, $urandom, 32'd2, 2'b00, 2'b01, 1, 32'hFFFF_FFFD, t, lat);
    wait_drain(lat);
    issue(3'b110, 32'hFFFF_FFF9, $urandom, $urandom, 32'd2, 2'b00, 2'b01, 1, 32'hFFFF_FFFF, t, lat);
    wait_drain(lat);
    // Fast paths
    issue(3'b101, 32'd5, 32'd0, $urandom, $urandom, 2'b00, 2'b00, 1, 32'hFFFF_FFFF, t, lat);
    wait_drain(lat);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, $urandom, $urandom, 2'b00, 2'b00, 1, 32'h0, t, lat);
    wait_drain(lat);

    // Flush during DIV at T+10
    issue(3'b100, 32'd1000, 32'd7, $urandom, $urandom, 2'b00, 2'b00, 0, 32'h0, t, lat);
    while (cyc < t + 10) begin @(posedge clk); #1; end
    flush_EX = 1'b1;
    @(posedge clk); #1;
    flush_EX = 1'b0;
    check_idle_outputs("flush");
    repeat (40) @(posedge clk);

    // Start coinciding with flush must not capture
    @(posedge clk); #1;
    md_start_EX = 1'b1; funct3_EX = 3'b000; flush_EX = 1'b1;
    #1;
    chk("start_flush_stall", {31'b0, stall_md}, 32'd0);
    @(posedge clk); #1;
    md_start_EX = 1'b0; flush_EX = 1'b0;
    chk("start_flush_busy", {31'b0, md_busy}, 32'd0);

    // Reset at T+5 during CALC
    issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, $urandom, $urandom, 2'b00, 2'b00, 0, 32'h0, t, lat);
    while (cyc < t + 5) begin @(posedge clk); #1; end
    chk("busy_before_reset", {31'b0, md_busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    repeat (40) @(posedge clk);

    // Hold for 3 cycles at DONE, then back-to-back MUL 3 x 4
    issue(3'b000, 32'd100, 32'd200, $urandom, $urandom, 2'b00, 2'b00, 1, 32'd20000, t, lat);
    begin
      int n;
      n = 0;
      while (!md_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("hold_done_reached", {31'b0, md_valid}, 32'd1);
      hold_EX = 1'b1;
      repeat (2) begin @(posedge clk); #1; chk("held_valid", {31'b0, md_valid}, 32'd1); end
      @(posedge clk); #1;
      hold_EX = 1'b0;
      chk("held_valid", {31'b0, md_valid}, 32'd1);
    end
    issue(3'b000, 32'd3, 32'd4, $urandom, $urandom, 2'b00, 2'b00, 1, 32'd12, t, lat);
    wait_drain(lat);

    // Randomized operations
    for (int i = 0; i < 48; i++) begin
      f3  = 3'($urandom_range(0, 7));
      r1  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      r2  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      mem = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      wb  = $urandom_range(0, 1) ? $urandom_range(0, 20) : $urandom;
      fa  = 2'($urandom_range(0, 3));
      fb  = 2'($urandom_range(0, 3));
      a   = pick(fa, r1, mem, wb);
      b   = pick(fb, r2, mem, wb);
      issue(f3, r1, r2, mem, wb, fa, fb, 1, ref_md(f3, a, b), t, lat);
      wait_drain(lat);
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide engine in the EX stage of the 5-stage pipeline, downstream of the forwarding unit. It selects each operand from the register-file value or the MEM/WB forwarded value using the forwarding unit's 2-bit codes, captures the operands on the start cycle, and runs a 32-iteration radix-2 shift-add or shift-subtract loop. It holds the front of the pipeline with `stall_md` until the result is ready.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (only 32 supported)
- `ITER`, 32, iterations per non-trivial operation

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  synchronous, active-high reset
- `md_start_EX`  in  1  valid M-extension instruction present in EX
- `funct3_EX`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_data_EX`, `rs2_data_EX`  in  32  register-file operands latched in ID/EX
- `fwd_data_MEM`  in  32  EX/MEM result
- `fwd_data_WB`  in  32  MEM/WB write-back data
- `forwardA`, `forwardB`  in  2  00 register file, 01 WB, 10 MEM (11 treated as 00)
- `flush_EX`  in  1  kill the instruction in EX (branch/jump redirect)
- `hold_EX`  in  1  external hold on EX/MEM advance
- `stall_md`  out  1  freeze PC, IF/ID, ID/EX; insert a bubble into EX/MEM
- `md_valid`  out  1  `md_result` is valid this cycle
- `md_result`  out  32  selected result
- `md_busy`  out  1  state is not IDLE

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - With `md_start_EX=1` and `flush_EX=0`: apply the forwarding mux to both operands and latch them with `funct3` in the same cycle. The MEM/WB sources drain while EX is stalled, so capturing later is not allowed.
  - Divide by zero, or signed DIV/REM of 0x8000_0000 by 0xFFFF_FFFF: go to DONE (fast path).
  - Otherwise: go to CALC and load the iteration counter with `ITER-1`.
- **Sign handling**
  - Take magnitudes of the signed operands: both operands for MULH/DIV/REM, rs1 only for MULHSU.
  - Run the loop unsigned, then negate at DONE.
  - Product sign: XOR of the operand signs. Quotient sign: XOR of the signs. Remainder sign: sign of the dividend.
- **CALC**
  - One iteration per cycle.
  - Multiply: 64-bit shift-add accumulator.
  - Divide: restoring, 32-bit remainder plus quotient shift register.
  - At counter 0, go to DONE.
- **Result selection**
  - MUL: low 32 bits of the product. MULH/MULHSU/MULHU: high 32 bits of the signed-corrected 64-bit product.
  - Divide by zero: quotient 0xFFFF_FFFF (DIV and DIVU), remainder = dividend.
  - Overflow (signed): quotient 0x8000_0000, remainder 0.
- **DONE**
  - `md_valid=1`, `stall_md=0`, `md_result` driven.
  - Go to IDLE unless `hold_EX=1`. While held, stay in DONE with the result stable.
- `flush_EX=1` in any state: next state IDLE, and `md_valid` is suppressed that cycle. If it coincides with `md_start_EX` in IDLE, no capture occurs.
- `md_result` is 0 whenever `md_valid=0`.

## Timing
- Reset:
  - State IDLE; counter, operand latches and accumulators cleared.
  - `stall_md=0`, `md_valid=0`, `md_result=0`, `md_busy=0`.
  - Reset mid-CALC abandons the operation with no valid pulse.
- `stall_md` is combinational: `(IDLE & md_start_EX & ~flush_EX) | CALC`.
- Normal operation: capture at cycle T, CALC T+1..T+32, DONE at T+33. The instruction occupies EX for 34 cycles.
- Fast path: capture at T, DONE at T+1, so 2 cycles in EX.
- Back-to-back M instructions: the second instruction reaches EX the cycle after DONE and is captured there from IDLE. No idle gap beyond that.
- Forwarding codes and forwarded data are sampled only in the capture cycle. Changes during CALC have no effect.

## Test plan
- MUL 7 × −3 from the register file (`forwardA/B=00`) -> at T+33, `md_valid=1`, `md_result=0xFFFF_FFEB`; `stall_md` high T..T+32.
- MULHU 0xFFFF_FFFF × 0xFFFF_FFFF with rs1 via `forwardA=10` (`fwd_data_MEM`), with `fwd_data_MEM` changing to garbage from T+1 -> `md_result=0xFFFF_FFFE`.
- DIV −7 / 2 with rs2 via `forwardB=01` -> `md_result=0xFFFF_FFFD`; REM −7 / 2 -> `0xFFFF_FFFF`.
- DIVU 5 / 0 -> DONE at T+1, `md_result=0xFFFF_FFFF`; REM 0x8000_0000 / 0xFFFF_FFFF -> DONE at T+1, `md_result=0`.
- `flush_EX` at T+10 during a DIV -> IDLE at T+11, no `md_valid`, `stall_md=0`. Separately, `rst` at T+5 -> all outputs 0 at T+6.
- `hold_EX=1` for 3 cycles at DONE -> `md_valid` and `md_result` stable for 4 cycles. Then an immediately following MUL 3 × 4 is captured the next cycle and yields 12 at 33 cycles after its capture.
